rv32i_mem_wb_stage: RTL and testbench

- Downstream of the execute stage: takes the EX/MEM pipeline register contents (IR, ALU result, store data) and performs the data-memory access.
- Presents the register-file writeback port (rd, data, write-enable).
- Owns the word-addressed data memory.
- Supports configurable memory wait states with a ready/valid stall back to execute.

---
 rtl/rv32i_mem_wb_stage.sv | 113 +++++++++++
 tb/tb_rv32i_mem_wb_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_wb_stage.sv
// rv32i_mem_wb_stage: MEM/WB stage with data memory, wait states and stall; `define MEMWB_BYPASS_EN adds MEM-stage forwarding outputs
module rv32i_mem_wb_stage #(
  parameter int DM_DEPTH = 32,
  parameter int ADDR_W   = 5,
  parameter int DM_WAIT  = 0
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              ex_valid,
  input  logic [31:0]       ex_ir,
  input  logic [31:0]       ex_aluout,
  input  logic [31:0]       ex_b,
  output logic              mem_ready,
  output logic [31:0]       WB_OUT,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              wb_valid,
  output logic [31:0]       wb_ir,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
`ifdef MEMWB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [31:0]       fwd_data
`endif
);
  localparam logic [6:0] AR_TYPE = 7'd0, M_TYPE = 7'd1, SH_TYPE = 7'd3;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            r_state, w_state_nx;
  logic [3:0]        r_cnt, w_cnt_nx;
  logic              r_m_valid;
  logic [31:0]       r_m_ir, r_m_alu, r_m_b;
  logic [31:0]       r_dm [DM_DEPTH];
  logic              w_accept, w_complete, w_ex_mem, w_m_lw, w_m_sw, w_m_arsh;
  logic [ADDR_W-1:0] w_m_addr;
  logic [4:0]        w_m_rd;
  logic [31:0]       w_wb_data;
  assign mem_ready  = r_state == IDLE;
  assign w_accept   = ex_valid && mem_ready;
  assign w_complete = r_m_valid && mem_ready;
  assign w_ex_mem   = ex_ir[6:0] == M_TYPE && ex_ir[14:12] < 3'd2;
  assign w_m_lw     = r_m_ir[6:0] == M_TYPE && r_m_ir[14:12] == 3'd0;
  assign w_m_sw     = r_m_ir[6:0] == M_TYPE && r_m_ir[14:12] == 3'd1;
  assign w_m_arsh   = r_m_ir[6:0] == AR_TYPE || r_m_ir[6:0] == SH_TYPE;
  assign w_m_addr   = r_m_alu[ADDR_W-1:0];
  assign w_m_rd     = r_m_ir[11:7];
  assign w_wb_data  = w_m_lw ? r_dm[w_m_addr] : w_m_arsh ? r_m_alu : 32'd0;
  assign dbg_data   = r_dm[dbg_addr];
`ifdef MEMWB_BYPASS_EN
  assign fwd_valid  = r_m_valid && w_m_arsh && w_m_rd != 5'd0;
  assign fwd_rd     = w_m_rd;
  assign fwd_data   = r_m_alu;
`endif
  // next state: count down wait states; enter WAIT when a load/store is accepted
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == WAIT) begin
      w_cnt_nx   = r_cnt - 4'd1;
      w_state_nx = r_cnt == 4'd1 ? IDLE : WAIT;
    end else if (w_accept && w_ex_mem && DM_WAIT > 0) begin
      w_state_nx = WAIT;
      w_cnt_nx   = 4'(DM_WAIT);
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (RN) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  // MEM register: reloads whenever the stage is ready, holds through wait states
  always_ff @(posedge clk) begin
    if (RN) begin
      r_m_valid <= 1'b0;
      r_m_ir    <= 32'd0;
      r_m_alu   <= 32'd0;
      r_m_b     <= 32'd0;
    end else if (mem_ready) begin
      r_m_valid <= ex_valid;
      if (w_accept) begin
        r_m_ir  <= ex_ir;
        r_m_alu <= ex_aluout;
        r_m_b   <= ex_b;
      end
    end
  end
  // completion: store to data memory and update the writeback register
  always_ff @(posedge clk) begin
    if (RN) begin
      for (int i = 0; i < DM_DEPTH; i++) r_dm[i] <= 32'd0;
      WB_OUT   <= 32'd0;
      wb_rd    <= 5'd0;
      wb_we    <= 1'b0;
      wb_valid <= 1'b0;
      wb_ir    <= 32'd0;
    end else begin
      if (w_complete && w_m_sw) r_dm[w_m_addr] <= r_m_b;
      wb_valid <= w_complete;
      wb_we    <= w_complete && (w_m_lw || w_m_arsh) && w_m_rd != 5'd0;
      if (w_complete) begin
        WB_OUT <= w_wb_data;
        wb_rd  <= w_m_rd;
        wb_ir  <= r_m_ir;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_mem_wb_stage.sv
// tb_rv32i_mem_wb_stage: scoreboard bench over three instances with DM_WAIT = 0, 2, 3
module tb_rv32i_mem_wb_stage;
  typedef struct packed {logic v; logic [31:0] ir; logic [31:0] alu; logic [31:0] b;} stim_t;
  typedef struct packed {logic [4:0] rd; logic we; logic [31:0] data; logic [31:0] ir; int cyc;} ret_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        RN [3], ex_valid [3], mem_ready [3], wb_we [3], wb_valid [3];
  logic [31:0] ex_ir [3], ex_aluout [3], ex_b [3], WB_OUT [3], wb_ir [3], dbg_data [3];
  logic [4:0]  wb_rd [3], dbg_addr [3];
`ifdef MEMWB_BYPASS_EN
  logic        fwd_valid [3];
  logic [4:0]  fwd_rd [3];
  logic [31:0] fwd_data [3];
`endif
  logic [31:0] mdl [3][32];
  stim_t stim[$];
  ret_t  exq[$], obsq[$];
  int errors = 0, checks = 0;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    rv32i_mem_wb_stage #(.DM_WAIT(g == 0 ? 0 : g + 1)) u_dut (
      .clk(clk), .RN(RN[g]), .ex_valid(ex_valid[g]), .ex_ir(ex_ir[g]),
      .ex_aluout(ex_aluout[g]), .ex_b(ex_b[g]), .mem_ready(mem_ready[g]),
      .WB_OUT(WB_OUT[g]), .wb_rd(wb_rd[g]), .wb_we(wb_we[g]), .wb_valid(wb_valid[g]),
      .wb_ir(wb_ir[g]), .dbg_addr(dbg_addr[g]), .dbg_data(dbg_data[g])
`ifdef MEMWB_BYPASS_EN
      , .fwd_valid(fwd_valid[g]), .fwd_rd(fwd_rd[g]), .fwd_data(fwd_data[g])
`endif
    );
  end

  // reference model of one retirement; updates the model memory for stores
  function automatic ret_t predict(input int k, input stim_t s, input int n);
    ret_t r;
    logic lw, sw, arsh;
    logic [4:0] a;
    lw   = s.ir[6:0] == 7'd1 && s.ir[14:12] == 3'd0;
    sw   = s.ir[6:0] == 7'd1 && s.ir[14:12] == 3'd1;
    arsh = s.ir[6:0] == 7'd0 || s.ir[6:0] == 7'd3;
    a    = s.alu[4:0];
    r.rd   = s.ir[11:7];
    r.ir   = s.ir;
    r.we   = (lw || arsh) && s.ir[11:7] != 5'd0;
    r.data = lw ? mdl[k][a] : arsh ? s.alu : 32'd0;
    r.cyc  = n + 1 + ((lw || sw) ? (k == 0 ? 0 : k + 1) : 0);
    if (sw) mdl[k][a] = s.b;
    return r;
  endfunction

  task automatic add(input logic v, input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b);
    stim_t s;
    s = '{v, ir, alu, b};
    stim.push_back(s);
  endtask

  // plays the stimulus queue into instance k, pushing predictions on accept and recording retirements
  task automatic drive(input int k);
    int n;
    logic rdy;
    ret_t o;
    n = 0;
    exq.delete();
    obsq.delete();
    while (stim.size() > 0 && n < 200) begin
      rdy = mem_ready[k];
      if (rdy) begin
        ex_valid[k] = stim[0].v; ex_ir[k] = stim[0].ir; ex_aluout[k] = stim[0].alu; ex_b[k] = stim[0].b;
      end else begin
        ex_valid[k] = 1'b1; ex_ir[k] = $urandom; ex_aluout[k] = $urandom; ex_b[k] = $urandom;
      end
      @(posedge clk);
      n++;
      if (rdy) begin
        if (stim[0].v) exq.push_back(predict(k, stim[0], n));
        stim.delete(0);
      end
      @(negedge clk);
      if (wb_valid[k]) begin o = '{wb_rd[k], wb_we[k], WB_OUT[k], wb_ir[k], n}; obsq.push_back(o); end
    end
    checks++;
    if (stim.size() != 0) begin errors++; $display("FAIL drive_timeout inst=%0d pending=%0d want 0", k, stim.size()); stim.delete(); end
    ex_valid[k] = 1'b0;
    repeat (6) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (wb_valid[k]) begin o = '{wb_rd[k], wb_we[k], WB_OUT[k], wb_ir[k], n}; obsq.push_back(o); end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      RN[k] = 1'b1; ex_valid[k] = 1'b0; ex_ir[k] = '0; ex_aluout[k] = '0; ex_b[k] = '0; dbg_addr[k] = '0;
      for (int a = 0; a < 32; a++) mdl[k][a] = 32'd0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) RN[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({wb_valid[k], wb_we[k], WB_OUT[k], mem_ready[k], wb_rd[k], wb_ir[k]} !== {1'b0, 1'b0, 32'd0, 1'b1, 5'd0, 32'd0}) begin
        errors++;
        $display("FAIL reset inst=%0d got valid=%b we=%b data=%h ready=%b rd=%0d ir=%h want 0 0 0 1 0 0",
                 k, wb_valid[k], wb_we[k], WB_OUT[k], mem_ready[k], wb_rd[k], wb_ir[k]);
      end
      for (int a = 0; a < 32; a++) begin
        dbg_addr[k] = 5'(a);
        #1;
        checks++;
        if (dbg_data[k] !== 32'd0) begin errors++; $display("FAIL reset_dm inst=%0d addr=%0d got=%h want 0", k, a, dbg_data[k]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ar();
    add(1'b1, 32'h02328400, 32'd50, 32'd0);
    drive(0);
    checks++;
    if (obsq.size() != exq.size()) begin errors++; $display("FAIL ar_count got=%0d want=%0d", obsq.size(), exq.size()); end
    foreach (exq[i]) if (i < obsq.size()) begin
      checks++;
      if (obsq[i] !== exq[i]) begin errors++; $display("FAIL ar_ret%0d got=%h want=%h", i, obsq[i], exq[i]); end
    end
    checks++;
    if (obsq.size() < 1 || {obsq[0].rd, obsq[0].we, obsq[0].data} !== {5'd8, 1'b1, 32'd50}) begin
      errors++; $display("FAIL ar_fields got n=%0d want rd=8 we=1 data=50", obsq.size());
    end
  endtask

  task automatic test_sw_lw();
    add(1'b1, 32'h00319181, 32'd12, 32'd30);
    add(1'b1, 32'h00428681, 32'd12, 32'd0);
    drive(0);
    checks++;
    if (obsq.size() != exq.size()) begin errors++; $display("FAIL swlw_count got=%0d want=%0d", obsq.size(), exq.size()); end
    foreach (exq[i]) if (i < obsq.size()) begin
      checks++;
      if (obsq[i] !== exq[i]) begin errors++; $display("FAIL swlw_ret%0d got=%h want=%h", i, obsq[i], exq[i]); end
    end
    checks++;
    if (obsq.size() < 2 || {obsq[0].we, obsq[1].rd, obsq[1].we, obsq[1].data, obsq[1].cyc - obsq[0].cyc} !== {1'b0, 5'd13, 1'b1, 32'd30, 32'sd1}) begin
      errors++; $display("FAIL swlw_fields got n=%0d want sw we=0 then lw rd=13 we=1 data=30 next cycle", obsq.size());
    end
    dbg_addr[0] = 5'd12;
    #1;
    checks++;
    if (dbg_data[0] !== 32'd30) begin errors++; $display("FAIL swlw_dm12 got=%h want=%h", dbg_data[0], 32'd30); end
  endtask

  task automatic test_suppressed();
    add(1'b1, 32'h00f10002, 32'd9, 32'd0);
    add(1'b1, 32'h00000000, 32'd7, 32'd0);
    add(1'b1, 32'h00319181, 32'h00000025, 32'hdeadbeef);
    add(1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b1, 32'h00428681, 32'hffffffe5, 32'd0);
    add(1'b1, 32'h00002381, 32'd5, 32'd1);
    add(1'b1, 32'h00000483, 32'd123, 32'd0);
    drive(0);
    checks++;
    if (obsq.size() != exq.size()) begin errors++; $display("FAIL supp_count got=%0d want=%0d", obsq.size(), exq.size()); end
    foreach (exq[i]) if (i < obsq.size()) begin
      checks++;
      if (obsq[i] !== exq[i]) begin errors++; $display("FAIL supp_ret%0d got=%h want=%h", i, obsq[i], exq[i]); end
    end
    checks++;
    if (obsq.size() < 2 || {obsq[0].we, obsq[1].we} !== 2'b00) begin
      errors++; $display("FAIL supp_br_rd0 got n=%0d want br we=0 and rd0 we=0", obsq.size());
    end
    dbg_addr[0] = 5'd5;
    #1;
    checks++;
    if (dbg_data[0] !== 32'hdeadbeef) begin errors++; $display("FAIL supp_wrap_dm5 got=%h want=deadbeef", dbg_data[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [5];
    ops = '{32'h02328400, 32'h00000483, 32'h00428681, 32'h00319181, 32'h00f10002};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++)
        add($urandom_range(0, 3) != 0, ops[$urandom_range(0, 4)],
            ($urandom & 32'hffffffe0) | 32'($urandom_range(0, 3)), $urandom);
      drive(k);
      checks++;
      if (obsq.size() != exq.size()) begin errors++; $display("FAIL b2b_count inst=%0d got=%0d want=%0d", k, obsq.size(), exq.size()); end
      foreach (exq[i]) if (i < obsq.size()) begin
        checks++;
        if (obsq[i] !== exq[i]) begin errors++; $display("FAIL b2b_ret inst=%0d #%0d got=%h want=%h", k, i, obsq[i], exq[i]); end
      end
    end
  endtask

  task automatic test_wait();
    add(1'b1, 32'h00319181, 32'd3, 32'd77);
    add(1'b1, 32'h00428681, 32'd3, 32'd0);
    add(1'b1, 32'h02328400, 32'd50, 32'd0);
    drive(1);
    checks++;
    if (obsq.size() != exq.size()) begin errors++; $display("FAIL wait_count got=%0d want=%0d", obsq.size(), exq.size()); end
    foreach (exq[i]) if (i < obsq.size()) begin
      checks++;
      if (obsq[i] !== exq[i]) begin errors++; $display("FAIL wait_ret%0d got=%h want=%h", i, obsq[i], exq[i]); end
    end
    ex_valid[1] = 1'b1; ex_ir[1] = 32'h00428681; ex_aluout[1] = 32'd3; ex_b[1] = 32'd0;
    checks++;
    if (mem_ready[1] !== 1'b1) begin errors++; $display("FAIL wait_ready_pre got=%b want 1", mem_ready[1]); end
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({mem_ready[1], wb_valid[1]} !== 2'b00) begin errors++; $display("FAIL wait_stall%0d got ready=%b valid=%b want 0 0", c, mem_ready[1], wb_valid[1]); end
      ex_ir[1] = 32'h02328400 ^ {$urandom_range(1, 255), 12'd0}; ex_aluout[1] = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if ({mem_ready[1], wb_valid[1]} !== 2'b10) begin errors++; $display("FAIL wait_release got ready=%b valid=%b want 1 0", mem_ready[1], wb_valid[1]); end
    ex_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wb_valid[1], wb_we[1], wb_rd[1], WB_OUT[1], wb_ir[1]} !== {1'b1, 1'b1, 5'd13, 32'd77, 32'h00428681}) begin
      errors++; $display("FAIL wait_lw got valid=%b we=%b rd=%0d data=%h ir=%h want 1 1 13 0000004d 00428681",
                         wb_valid[1], wb_we[1], wb_rd[1], WB_OUT[1], wb_ir[1]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wb_valid[1] !== 1'b0) begin errors++; $display("FAIL wait_ignored got valid=%b want 0", wb_valid[1]); end
  endtask

  task automatic test_reset_midwait();
    int pulses;
    add(1'b1, 32'h00319181, 32'd6, 32'd5);
    add(1'b1, 32'h00428681, 32'd6, 32'd0);
    drive(2);
    checks++;
    if (obsq.size() != exq.size()) begin errors++; $display("FAIL w3_count got=%0d want=%0d", obsq.size(), exq.size()); end
    foreach (exq[i]) if (i < obsq.size()) begin
      checks++;
      if (obsq[i] !== exq[i]) begin errors++; $display("FAIL w3_ret%0d got=%h want=%h", i, obsq[i], exq[i]); end
    end
    ex_valid[2] = 1'b1; ex_ir[2] = 32'h00319181; ex_aluout[2] = 32'd4; ex_b[2] = 32'd99;
    @(posedge clk);
    @(negedge clk);
    ex_valid[2] = 1'b0;
    checks++;
    if (mem_ready[2] !== 1'b0) begin errors++; $display("FAIL rstw_stall got=%b want 0", mem_ready[2]); end
    @(posedge clk);
    @(negedge clk);
    RN[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RN[2] = 1'b0;
    checks++;
    if ({mem_ready[2], wb_valid[2]} !== 2'b10) begin errors++; $display("FAIL rstw_after got ready=%b valid=%b want 1 0", mem_ready[2], wb_valid[2]); end
    pulses = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_valid[2] !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rstw_pulses got=%0d want 0", pulses); end
    dbg_addr[2] = 5'd4;
    #1;
    checks++;
    if (dbg_data[2] !== 32'd0) begin errors++; $display("FAIL rstw_dm4 got=%h want 0", dbg_data[2]); end
  endtask

  initial begin
    test_reset();
    test_ar();
    test_sw_lw();
    test_suppressed();
    test_back_to_back();
    test_wait();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
